// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/write-back and drives every datapath select and enable.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_LW    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_WB_I     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // fetch/jump_wr/branch are internal qualifiers combined with mem_ready/zero
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic       fetch;
    logic       jump_wr;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b100;
        c.fetch     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 3'b100;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b100;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_WB_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b111;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: c.alu_op = 3'b000;
          OP_ORI:  c.alu_op = 3'b001;
          OP_LUI:  c.alu_op = 3'b101;
          default: c.alu_op = 3'b100;
        endcase
      end
      S_WB_I:   c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b110;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src  = 2'b10;
        c.jump_wr = 1'b1;
      end
      S_JR: begin
        c.pc_src  = 2'b11;
        c.jump_wr = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t cur, nxt;
  ctrl_t  c_q;

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         nxt = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                     nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
          OP_J:                             nxt = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxt = S_EXEC_I;
          default:                          nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = mem_ready ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   nxt = S_WB_R;
      S_EXEC_I:   nxt = S_WB_I;
      S_WB_LW, S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_JR: nxt = S_FETCH;
      default:    nxt = S_TRAP;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with it;
  // opcode is held by the IR for the whole instruction after FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
      c_q <= decode(S_FETCH, 6'd0);
    end else begin
      cur <= nxt;
      c_q <= decode(nxt, opcode);
    end
  end

  assign state      = cur;
  assign mem_read   = c_q.mem_read;
  assign mem_write  = c_q.mem_write;
  assign i_or_d     = c_q.i_or_d;
  assign reg_write  = c_q.reg_write;
  assign reg_dst    = c_q.reg_dst;
  assign mem_to_reg = c_q.mem_to_reg;
  assign alu_src_a  = c_q.alu_src_a;
  assign alu_src_b  = c_q.alu_src_b;
  assign alu_op     = c_q.alu_op;
  assign pc_src     = c_q.pc_src;
  assign illegal    = c_q.illegal;
  assign ir_write   = c_q.fetch & mem_ready;
  assign pc_write   = (c_q.fetch & mem_ready) | c_q.jump_wr |
                      (c_q.branch & ((opcode == OP_BNE) ? ~zero : zero));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks selects, enables and memory-stall behaviour.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] state;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  int tests  = 0;
  int failed = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .state(state), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  int lw_st[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
  logic lw_mr[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int ir_pulses;
  int m2r_bad;

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_illegal", illegal, 0);
    #9;
    reset = 1'b0;

    // R-type ADD
    mem_ready = 1'b1;
    #1;
    chk("r_fetch_ir_write", ir_write, 1);
    chk("r_fetch_pc_write", pc_write, 1);
    chk("r_fetch_alu_src_b", alu_src_b, 1);
    chk("r_fetch_alu_op", alu_op, 4);
    go();
    chk("r_decode_state", state, 1);
    chk("r_decode_alu_src_b", alu_src_b, 3);
    chk("r_decode_reg_write", reg_write, 0);
    go();
    chk("r_exec_state", state, 6);
    chk("r_exec_alu_op", alu_op, 7);
    chk("r_exec_reg_write", reg_write, 0);
    go();
    chk("r_wb_state", state, 7);
    chk("r_wb_reg_write", reg_write, 1);
    chk("r_wb_reg_dst", reg_dst, 1);
    go();
    chk("r_done_state", state, 0);
    chk("r_done_reg_write", reg_write, 0);

    // LW with 2 FETCH and 3 MEM_RD wait cycles
    opcode = 6'h23;
    ir_pulses = 0;
    m2r_bad = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = lw_mr[i];
      #1;
      chk($sformatf("lw_state_%0d", i), state, lw_st[i]);
      if (ir_write) ir_pulses++;
      if (mem_to_reg !== (lw_st[i] == 4)) m2r_bad++;
      go();
    end
    chk("lw_ir_pulses", ir_pulses, 1);
    chk("lw_mem_to_reg_only_wb", m2r_bad, 0);
    chk("lw_done_state", state, 0);

    // Asynchronous reset while stalled in MEM_RD
    mem_ready = 1'b1;
    go();
    go();
    mem_ready = 1'b0;
    go();
    chk("rrd_state", state, 3);
    chk("rrd_mem_read", mem_read, 1);
    chk("rrd_i_or_d", i_or_d, 1);
    go();
    chk("rrd_hold_state", state, 3);
    #2 reset = 1'b1;
    #1;
    chk("rrd_reset_state", state, 0);
    chk("rrd_reset_illegal", illegal, 0);
    chk("rrd_reset_reg_write", reg_write, 0);
    chk("rrd_reset_i_or_d", i_or_d, 0);
    #1 reset = 1'b0;

    // BEQ taken
    opcode = 6'h04; zero = 1'b1; mem_ready = 1'b1;
    go();
    go();
    chk("beq_state", state, 8);
    chk("beq_pc_write", pc_write, 1);
    chk("beq_pc_src", pc_src, 1);
    chk("beq_alu_op", alu_op, 6);
    go();
    chk("beq_done_state", state, 0);

    // BNE: zero=1 not taken, zero=0 taken
    opcode = 6'h05;
    go();
    go();
    chk("bne_state", state, 8);
    chk("bne_z1_pc_write", pc_write, 0);
    zero = 1'b0;
    #1;
    chk("bne_z0_pc_write", pc_write, 1);
    go();
    chk("bne_done_state", state, 0);

    // ORI
    opcode = 6'h0D;
    go();
    go();
    chk("ori_state", state, 10);
    chk("ori_alu_op", alu_op, 1);
    chk("ori_alu_src_b", alu_src_b, 2);
    chk("ori_alu_src_a", alu_src_a, 1);
    go();
    chk("ori_wb_state", state, 11);
    chk("ori_wb_reg_write", reg_write, 1);
    chk("ori_wb_reg_dst", reg_dst, 0);
    go();
    chk("ori_done_state", state, 0);

    // LUI
    opcode = 6'h0F;
    go();
    go();
    chk("lui_alu_op", alu_op, 5);
    go();
    go();
    chk("lui_done_state", state, 0);

    // JR
    opcode = 6'h00; funct = 6'h08;
    go();
    go();
    chk("jr_state", state, 12);
    chk("jr_pc_src", pc_src, 3);
    chk("jr_pc_write", pc_write, 1);
    go();
    chk("jr_done_state", state, 0);

    // J
    opcode = 6'h02;
    go();
    go();
    chk("j_state", state, 9);
    chk("j_pc_src", pc_src, 2);
    chk("j_pc_write", pc_write, 1);
    go();
    chk("j_done_state", state, 0);

    // SW with one wait cycle
    opcode = 6'h2B;
    go();
    go();
    chk("sw_addr_state", state, 2);
    chk("sw_addr_alu_src_b", alu_src_b, 2);
    mem_ready = 1'b0;
    go();
    chk("sw_wr_state", state, 5);
    chk("sw_mem_write", mem_write, 1);
    chk("sw_mem_read", mem_read, 0);
    chk("sw_i_or_d", i_or_d, 1);
    go();
    chk("sw_hold_state", state, 5);
    mem_ready = 1'b1;
    go();
    chk("sw_done_state", state, 0);

    // Illegal opcode traps until reset
    opcode = 6'h3F; zero = 1'b1;
    go();
    go();
    chk("trap_state", state, 15);
    chk("trap_illegal", illegal, 1);
    for (int i = 0; i < 20; i++) begin
      go();
      chk($sformatf("trap_hold_state_%0d", i), state, 15);
      chk($sformatf("trap_hold_illegal_%0d", i), illegal, 1);
      chk($sformatf("trap_enables_%0d", i),
          {reg_write, pc_write, mem_write, mem_read, ir_write}, 0);
    end
    #2 reset = 1'b1;
    #1;
    chk("trap_reset_state", state, 0);
    chk("trap_reset_illegal", illegal, 0);
    #1 reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back over several cycles, drives all datapath mux selects, register and memory enables, and the 3-bit `alu_op` code consumed by the ALU control unit. It sits between the instruction register (opcode/funct) and the shared PC/IR/RegFile/ALU/memory datapath, and it stalls on a single-port memory handshake.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]
- `funct` in 6: IR[5:0]
- `zero` in 1: ALU zero flag (valid in BRANCH state)
- `mem_ready` in 1: memory completes the current access this cycle
- `state` out 4: current state code (debug)
- `pc_write` out 1, `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR)
- `ir_write` out 1; `mem_read` out 1; `mem_write` out 1; `i_or_d` out 1 (0 PC, 1 ALUOut)
- `reg_write` out 1; `reg_dst` out 1 (0 rt, 1 rd); `mem_to_reg` out 1
- `alu_src_a` out 1 (0 PC, 1 A); `alu_src_b` out 2 (00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2)
- `alu_op` out 3: 000 AND, 001 OR, 100 ADD, 101 LUI, 110 SUB/compare, 111 R-type (use funct)
- `illegal` out 1: sticky unsupported-instruction flag

## Operation
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, WB_LW 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11, JR 12, TRAP 15.
- Outputs are Moore decodes of `state`, except the `mem_ready`- and `zero`-qualified enables below. Unlisted outputs are 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=100, `pc_src`=00. `ir_write` and `pc_write` are driven equal to `mem_ready`. The FSM stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=100 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R, or JR if `funct`=001000.
  - 100011 LW, 101011 SW → MEM_ADDR.
  - 000100 BEQ, 000101 BNE → BRANCH.
  - 000010 J → JUMP.
  - 001000 ADDI, 001100 ANDI, 001101 ORI, 001111 LUI → EXEC_I.
  - Anything else → TRAP.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=100. Goes to MEM_RD for LW, MEM_WR for SW (opcode held stable by IR).
- MEM_RD: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to WB_LW.
- WB_LW: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, then FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111, then WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, then FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10. `alu_op` is ADDI 100, ANDI 000, ORI 001, LUI 101. Then WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=110, `pc_src`=01. `pc_write` = `zero` for BEQ, `!zero` for BNE. Then FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, then FETCH.
- JR: `pc_src`=11, `pc_write`=1, then FETCH.
- TRAP: `illegal`=1. All enables are 0. The FSM stays in TRAP until reset.
- `mem_read` and `mem_write` are never both 1. `reg_write` and `pc_write` never assert outside the states listed.

## Timing
- Reset (asynchronous, any cycle, including mid-wait in MEM_RD/MEM_WR): `state` = FETCH (0) immediately and `illegal` = 0. Outputs then take FETCH values, so `mem_read`=1 and all write enables are 0 until `mem_ready`.
- One state transition per rising edge.
- With `mem_ready` tied to 1, cycles per instruction are:
  - LW: 5
  - SW, R-type, I-arith: 4
  - BEQ, BNE, J, JR: 3
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle. Outputs hold constant during the wait.
- `mem_ready` asserted in states that are not memory states is ignored.
- `zero` is sampled only in BRANCH, in the same cycle it is produced.

## Test plan
- Reset mid-MEM_RD with `mem_ready`=0 → `state`=0, `illegal`=0, `reg_write`=0 before the next edge.
- R-type ADD (opcode 0, funct 100000), `mem_ready`=1 → states 0,1,6,7,0. `alu_op`=111 in state 6. `reg_write`=1, `reg_dst`=1 only in state 7.
- LW with `mem_ready` low for 2 cycles in FETCH and 3 in MEM_RD → 10 cycles total. `ir_write` pulses once. `mem_to_reg`=1 only in WB_LW.
- BEQ with `zero`=1 → `pc_write`=1, `pc_src`=01 in state 8. BNE with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- ORI (001101) → `alu_op`=001, `alu_src_b`=10 in state 10. LUI (001111) → `alu_op`=101. JR (funct 001000) → state 12, `pc_src`=11.
- Opcode 111111 → state 15, `illegal`=1 held for 20 cycles with no write enables; reset clears it.
